// File: rtl/rob_pkg.sv
// Shared reorder buffer types and constants.
// Entry record, tag widths and slot-to-tag helper.
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int TAG_W = 5;
  localparam int RD_W = 5;
  localparam int VAL_W = 32;
  localparam logic [TAG_W-1:0] NULL_TAG = '0;

  typedef struct packed {
    logic             busy;
    logic             ready;
    logic [RD_W-1:0]  rd;
    logic [VAL_W-1:0] value;
  } rob_entry_t;

  function automatic logic [TAG_W-1:0] tag_of(input int slot);
    return TAG_W'(slot + 1);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer with tag rename requests.
// Tags are slot+1; tag 0 is the null tag.
module reorder_buffer #(
  parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush,
  input  logic                      issue_valid,
  input  logic [rob_pkg::RD_W-1:0]  issue_rd,
  output logic [rob_pkg::TAG_W-1:0] issue_entry,
  output logic                      full,
  input  logic                      wb_valid,
  input  logic [rob_pkg::TAG_W-1:0] wb_entry,
  input  logic [rob_pkg::VAL_W-1:0] wb_value,
  input  logic [rob_pkg::TAG_W-1:0] query_tag,
  output logic                      query_ready,
  output logic [rob_pkg::VAL_W-1:0] query_value,
  output logic                      reorder,
  output logic [rob_pkg::TAG_W-1:0] reorder_entry,
  output logic [rob_pkg::RD_W-1:0]  reorder_rd,
  output logic                      modify,
  output logic [rob_pkg::TAG_W-1:0] modify_entry,
  output logic [rob_pkg::RD_W-1:0]  modify_index,
  output logic [rob_pkg::VAL_W-1:0] modify_value
);

  import rob_pkg::*;

  localparam int PW = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
  localparam int CW = $clog2(ROB_DEPTH + 1);

  rob_entry_t      entries [ROB_DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   head_nx;
  logic [PW-1:0]   tail_nx;
  logic [CW-1:0]   count;
  rob_entry_t      hd;
  logic            issue_acc;
  logic            commit;
  logic            wb_hit;
  logic [PW-1:0]   wb_slot;
  logic            q_hit;
  logic [PW-1:0]   q_slot;
  logic [TAG_W-1:0] younger;

  assign full = (count == CW'(ROB_DEPTH));
  assign issue_entry = full ? NULL_TAG : tag_of(int'(tail));

  assign head_nx = (int'(head) == ROB_DEPTH - 1) ? '0 : head + PW'(1);
  assign tail_nx = (int'(tail) == ROB_DEPTH - 1) ? '0 : tail + PW'(1);

  assign hd = entries[head];
  assign issue_acc = rdy_in && !flush && issue_valid && !full;
  assign commit = rdy_in && !flush && hd.busy && hd.ready;

  // Decode writeback and query tags into slots; out-of-range tags miss.
  always_comb begin
    wb_hit = 1'b0;
    wb_slot = '0;
    q_hit = 1'b0;
    q_slot = '0;
    if (wb_entry != NULL_TAG && int'(wb_entry) <= ROB_DEPTH) begin
      wb_slot = PW'(int'(wb_entry) - 1);
      wb_hit = rdy_in && !flush && wb_valid
             && entries[wb_slot].busy;
    end
    if (query_tag != NULL_TAG && int'(query_tag) <= ROB_DEPTH) begin
      q_slot = PW'(int'(query_tag) - 1);
      q_hit = entries[q_slot].busy && entries[q_slot].ready;
    end
  end

  // Youngest other writer of the committing rd; a same-cycle issue wins.
  always_comb begin
    int s;
    logic [PW-1:0] idx;
    younger = NULL_TAG;
    s = 0;
    idx = '0;
    for (int k = 1; k < ROB_DEPTH; k++) begin
      s = int'(head) + k;
      if (s >= ROB_DEPTH) s = s - ROB_DEPTH;
      idx = PW'(s);
      if (k < int'(count) && entries[idx].busy
          && entries[idx].rd == hd.rd)
        younger = tag_of(s);
    end
    if (issue_acc && issue_rd == hd.rd)
      younger = issue_entry;
  end

  // Rename and commit requests; everything but full/issue_entry gated.
  always_comb begin
    reorder = issue_acc && issue_rd != '0;
    reorder_entry = reorder ? issue_entry : NULL_TAG;
    reorder_rd = reorder ? issue_rd : '0;
    modify = commit && hd.rd != '0;
    modify_entry = modify ? younger : NULL_TAG;
    modify_index = modify ? hd.rd : '0;
    modify_value = modify ? hd.value : '0;
    query_ready = rdy_in && q_hit;
    query_value = query_ready ? entries[q_slot].value : '0;
  end

  // Pointer, count and entry state; reset and flush empty the buffer.
  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && flush)) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < ROB_DEPTH; i++)
        entries[i] <= '0;
    end else if (rdy_in) begin
      if (issue_acc) begin
        entries[tail] <= '{busy: 1'b1, ready: 1'b0,
                           rd: issue_rd, value: '0};
        tail <= tail_nx;
      end
      if (wb_hit) begin
        entries[wb_slot].ready <= 1'b1;
        entries[wb_slot].value <= wb_value;
      end
      if (commit) begin
        entries[head].busy <= 1'b0;
        entries[head].ready <= 1'b0;
        head <= head_nx;
      end
      count <= count + CW'(issue_acc) - CW'(commit);
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer.
// Stimulus queues expected rename/commit events; a monitor checks them.
module tb_reorder_buffer;

  typedef struct packed {
    logic [4:0] entry;
    logic [4:0] rd;
  } ro_t;

  typedef struct packed {
    logic [4:0]  entry;
    logic [4:0]  idx;
    logic [31:0] value;
  } mo_t;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_entry;
  logic        full;
  logic        wb_valid;
  logic [4:0]  wb_entry;
  logic [31:0] wb_value;
  logic [4:0]  query_tag;
  logic        query_ready;
  logic [31:0] query_value;
  logic        reorder;
  logic [4:0]  reorder_entry;
  logic [4:0]  reorder_rd;
  logic        modify;
  logic [4:0]  modify_entry;
  logic [4:0]  modify_index;
  logic [31:0] modify_value;

  int checks = 0;
  int errors = 0;
  ro_t exp_ro[$];
  mo_t exp_mo[$];
  ro_t ro_cur;
  mo_t mo_cur;

  reorder_buffer #(.ROB_DEPTH(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .flush(flush), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_entry(issue_entry),
    .full(full), .wb_valid(wb_valid), .wb_entry(wb_entry),
    .wb_value(wb_value), .query_tag(query_tag),
    .query_ready(query_ready), .query_value(query_value),
    .reorder(reorder), .reorder_entry(reorder_entry),
    .reorder_rd(reorder_rd), .modify(modify),
    .modify_entry(modify_entry), .modify_index(modify_index),
    .modify_value(modify_value)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] tag);
    issue_valid = 1'b1;
    issue_rd = rd;
    if (rd != 5'd0) exp_ro.push_back('{entry: tag, rd: rd});
  endtask

  task automatic wb(input logic [4:0] tag, input logic [31:0] v);
    wb_valid = 1'b1;
    wb_entry = tag;
    wb_value = v;
  endtask

  task automatic exp_mod(input logic [4:0] e, input logic [4:0] i,
                         input logic [31:0] v);
    exp_mo.push_back('{entry: e, idx: i, value: v});
  endtask

  // Compare every presented rename/commit against the queued model.
  always @(negedge clk_in) begin
    if (reorder === 1'b1) begin
      if (exp_ro.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL reorder_unexp: got tag %0d rd %0d expected none",
                 reorder_entry, reorder_rd);
      end else begin
        ro_cur = exp_ro.pop_front();
        check("reorder_entry", 32'(reorder_entry), 32'(ro_cur.entry));
        check("reorder_rd", 32'(reorder_rd), 32'(ro_cur.rd));
      end
    end
    if (modify === 1'b1) begin
      if (exp_mo.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL modify_unexp: got idx %0d val %0h expected none",
                 modify_index, modify_value);
      end else begin
        mo_cur = exp_mo.pop_front();
        check("modify_entry", 32'(modify_entry), 32'(mo_cur.entry));
        check("modify_index", 32'(modify_index), 32'(mo_cur.idx));
        check("modify_value", modify_value, mo_cur.value);
      end
    end
  end

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    flush = 1'b0;
    issue_valid = 1'b0;
    issue_rd = '0;
    wb_valid = 1'b0;
    wb_entry = '0;
    wb_value = '0;
    query_tag = '0;
    step();
    do_reset();
    check("rst_full", 32'(full), 32'd0);
    check("rst_issue_entry", 32'(issue_entry), 32'd1);
    check("rst_reorder", 32'(reorder), 32'd0);
    check("rst_modify", 32'(modify), 32'd0);

    // basic issue, writeback, commit
    issue(5'd5, 5'd1);
    step();
    issue_valid = 1'b0;
    exp_mod(5'd0, 5'd5, 32'hAB);
    wb(5'd1, 32'hAB);
    #1;
    check("mod_latency", 32'(modify), 32'd0);
    step();
    wb_valid = 1'b0;
    step();

    // two writers of rd 3
    do_reset();
    issue(5'd3, 5'd1);
    step();
    issue(5'd3, 5'd2);
    step();
    issue_valid = 1'b0;
    exp_mod(5'd2, 5'd3, 32'h11);
    exp_mod(5'd0, 5'd3, 32'h22);
    wb(5'd1, 32'h11);
    step();
    wb(5'd2, 32'h22);
    step();
    wb_valid = 1'b0;
    step();
    step();

    // fill, ignored issue, wrap, simultaneous issue and commit
    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue(5'(i + 1), 5'(i + 1));
      step();
    end
    issue_valid = 1'b0;
    check("full16", 32'(full), 32'd1);
    issue_valid = 1'b1;
    issue_rd = 5'd20;
    exp_mod(5'd0, 5'd1, 32'h100);
    wb(5'd1, 32'h100);
    step();
    issue_valid = 1'b0;
    check("full_ignored", 32'(full), 32'd1);
    exp_mod(5'd1, 5'd2, 32'h200);
    wb(5'd2, 32'h200);
    step();
    wb_valid = 1'b0;
    check("full_after_commit", 32'(full), 32'd0);
    check("wrap_entry", 32'(issue_entry), 32'd1);
    issue(5'd2, 5'd1);
    step();
    issue_valid = 1'b0;
    check("count_kept", 32'(full), 32'd0);
    check("next_entry", 32'(issue_entry), 32'd2);
    issue(5'd22, 5'd2);
    step();
    issue_valid = 1'b0;
    check("refull", 32'(full), 32'd1);

    // mid-operation reset discards everything
    do_reset();
    check("rst2_full", 32'(full), 32'd0);
    check("rst2_entry", 32'(issue_entry), 32'd1);

    // rd 0 commits silently but advances head
    issue(5'd0, 5'd1);
    #1;
    check("rd0_reorder", 32'(reorder), 32'd0);
    step();
    issue_valid = 1'b0;
    wb(5'd1, 32'h55);
    step();
    wb_valid = 1'b0;
    step();
    issue(5'd7, 5'd2);
    step();
    issue_valid = 1'b0;
    exp_mod(5'd0, 5'd7, 32'h77);
    wb(5'd2, 32'h77);
    step();
    wb_valid = 1'b0;
    step();
    step();

    // flush with 4 in flight, 2 ready
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(5'(i + 1), 5'(i + 1));
      step();
    end
    issue_valid = 1'b0;
    wb(5'd3, 32'h33);
    step();
    wb(5'd4, 32'h44);
    step();
    wb_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_modify", 32'(modify), 32'd0);
    step();
    flush = 1'b0;
    check("flush_full", 32'(full), 32'd0);
    check("flush_entry", 32'(issue_entry), 32'd1);
    query_tag = 5'd3;
    #1;
    check("flush_query", 32'(query_ready), 32'd0);
    step();
    step();
    step();

    // query timing around writeback
    do_reset();
    issue(5'd9, 5'd1);
    step();
    issue(5'd10, 5'd2);
    step();
    issue_valid = 1'b0;
    query_tag = 5'd2;
    #1;
    check("q_pre_wb", 32'(query_ready), 32'd0);
    wb(5'd2, 32'hCAFE);
    #1;
    check("q_in_wb", 32'(query_ready), 32'd0);
    step();
    wb_valid = 1'b0;
    check("q_after_wb", 32'(query_ready), 32'd1);
    check("q_value", query_value, 32'hCAFE);
    exp_mod(5'd0, 5'd9, 32'h9);
    exp_mod(5'd0, 5'd10, 32'hCAFE);
    wb(5'd1, 32'h9);
    step();
    wb_valid = 1'b0;
    step();
    step();

    // global enable low holds state
    rdy_in = 1'b0;
    issue_valid = 1'b1;
    issue_rd = 5'd4;
    #1;
    check("rdy_low_entry", 32'(issue_entry), 32'd3);
    check("rdy_low_reorder", 32'(reorder), 32'd0);
    step();
    rdy_in = 1'b1;
    issue_valid = 1'b0;
    check("rdy_hold", 32'(issue_entry), 32'd3);
    step();
    step();

    check("reorder_left", 32'(exp_ro.size()), 32'd0);
    check("modify_left", 32'(exp_mo.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
